icache_refill_ctrl: RTL and testbench

- Miss/refill sequencer for the 16-bit RICS instruction cache (16-bit address, 64-bit line = 4 instructions).
- Sits between the fetch stage, the cache, and instruction memory.
- Serves hits directly; on a miss it stalls fetch, reads the line from memory in four 16-bit beats, writes it into the cache, and delivers the missed instruction.

---
 rtl/rics_cache_pkg.sv | 11 +
 rtl/refill_line_buffer.sv | 32 +++
 rtl/icache_refill_ctrl.sv | 97 +++++++++
 tb/tb_icache_refill_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rics_cache_pkg.sv
// rics_cache_pkg: shared state encoding, line geometry and address helpers for the I-cache refill path
package rics_cache_pkg;
   typedef enum logic [1:0] {IDLE, REQ, FILL, ERROR} state_t;
   localparam int LINE_WIDTH = 64;
   localparam int OFFSET_LSB = 1;
   localparam int OFFSET_MSB = 2;
   localparam int LINE_LSB   = 3;
   function automatic logic [15:0] line_align(input logic [15:0] a);
      return {a[15:LINE_LSB], {LINE_LSB{1'b0}}};
   endfunction
endpackage

// File: rtl/refill_line_buffer.sv
// refill_line_buffer: beat counter plus line assembly for one cache refill
//   i_clear resets the beat counter at the start of a refill; i_ack stores i_data
//   at the current beat slot; o_last flags the ack that completes the line.
module refill_line_buffer #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic           inp_clk,
   input  logic           inp_rst,
   input  logic           i_clear,
   input  logic           i_ack,
   input  logic [W-1:0]   i_data,
   output logic [W*N-1:0] o_line,
   output logic           o_last
);
   localparam int CW = $clog2(N);
   logic [CW-1:0]  r_cnt;
   logic [W*N-1:0] r_line;
   assign o_line = r_line;
   assign o_last = i_ack && r_cnt == CW'(N - 1);
   always_ff @(posedge inp_clk or posedge inp_rst) begin
      if (inp_rst) begin
         r_cnt  <= '0;
         r_line <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_ack) begin
         r_line[r_cnt*W +: W] <= i_data;
         r_cnt                <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss/refill sequencer between fetch, the I-cache and instruction memory
//   fetch side : inp_fetchReq, inp_address -> out_instruction, out_valid, out_stall
//   cache side : out_cacheAddress, inp_cacheHit, inp_cacheInstruction, out_cacheWrite, out_cacheLine
//   memory side: out_memReq, out_memAddress, inp_memAck, inp_memData
//   status     : out_error (sticky timeout), out_missCount (saturating)
module icache_refill_ctrl
   import rics_cache_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 16,
   parameter int          INSTR_WIDTH    = 16,
   parameter int          WORDS_PER_LINE = 4,
   parameter int          MEM_TIMEOUT    = 64,
   parameter logic [15:0] MISS_SAT       = 16'hFFFF
) (
   input  logic                   inp_clk,
   input  logic                   inp_rst,
   input  logic                   inp_fetchReq,
   input  logic [ADDR_WIDTH-1:0]  inp_address,
   input  logic                   inp_cacheHit,
   input  logic [INSTR_WIDTH-1:0] inp_cacheInstruction,
   output logic [ADDR_WIDTH-1:0]  out_cacheAddress,
   output logic                   out_cacheWrite,
   output logic [LINE_WIDTH-1:0]  out_cacheLine,
   output logic                   out_memReq,
   output logic [ADDR_WIDTH-1:0]  out_memAddress,
   input  logic                   inp_memAck,
   input  logic [INSTR_WIDTH-1:0] inp_memData,
   output logic [INSTR_WIDTH-1:0] out_instruction,
   output logic                   out_valid,
   output logic                   out_stall,
   output logic                   out_error,
   output logic [15:0]            out_missCount
);
   localparam int TW = $clog2(MEM_TIMEOUT) + 1;
   state_t                 r_state;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [TW-1:0]          r_tmo;
   logic [15:0]            r_miss;
   logic [LINE_WIDTH-1:0]  w_line;
   logic                   w_last;
   logic                   w_hit;
   logic                   w_miss;
   logic                   w_ack;
   logic [INSTR_WIDTH-1:0] w_word;
   assign w_hit  = r_state == IDLE && inp_fetchReq && inp_cacheHit;
   assign w_miss = r_state == IDLE && inp_fetchReq && !inp_cacheHit;
   // acks are only meaningful while a line read is outstanding
   assign w_ack  = r_state == REQ && inp_memAck;
   refill_line_buffer #(.W(INSTR_WIDTH), .N(WORDS_PER_LINE)) u_buf (
      .inp_clk (inp_clk),
      .inp_rst (inp_rst),
      .i_clear (w_miss),
      .i_ack   (w_ack),
      .i_data  (inp_memData),
      .o_line  (w_line),
      .o_last  (w_last)
   );
   // critical word comes from the assembled buffer, not a second cache read
   assign w_word = w_line[r_addr[OFFSET_MSB:OFFSET_LSB]*INSTR_WIDTH +: INSTR_WIDTH];
   always_ff @(posedge inp_clk or posedge inp_rst) begin
      if (inp_rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_tmo   <= '0;
         r_miss  <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_miss) begin
               r_state <= REQ;
               r_addr  <= inp_address;
               r_tmo   <= '0;
               r_miss  <= r_miss == MISS_SAT ? r_miss : r_miss + 1'b1;
            end
            REQ: if (inp_memAck) begin
               r_tmo <= '0;
               if (w_last) r_state <= FILL;
            end else if (r_tmo == TW'(MEM_TIMEOUT - 1)) begin
               r_state <= ERROR;
            end else begin
               r_tmo <= r_tmo + 1'b1;
            end
            FILL: r_state <= IDLE;
            default: ;
         endcase
      end
   end
   assign out_cacheAddress = r_state == IDLE ? inp_address : r_addr;
   assign out_cacheWrite   = r_state == FILL;
   assign out_cacheLine    = w_line;
   assign out_memReq       = r_state == REQ;
   assign out_memAddress   = line_align(r_addr);
   assign out_valid        = w_hit || (r_state == FILL && inp_fetchReq);
   assign out_instruction  = w_hit ? inp_cacheInstruction : r_state == FILL ? w_word : '0;
   assign out_stall        = w_miss || r_state == REQ || r_state == ERROR;
   assign out_error        = r_state == ERROR;
   assign out_missCount    = r_miss;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;
   logic        clk = 0;
   logic        rst = 1;
   logic        fetch_req = 0;
   logic [15:0] address = 0;
   logic        cache_hit = 0;
   logic [15:0] cache_instr = 0;
   logic [15:0] cache_addr;
   logic        cache_write;
   logic [63:0] cache_line;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 0;
   logic [15:0] mem_data = 0;
   logic [15:0] instr;
   logic        valid;
   logic        stall;
   logic        error;
   logic [15:0] miss_cnt;
   int          n_tot = 0;
   int          n_bad = 0;
   always #5 clk = ~clk;
   icache_refill_ctrl #(.MISS_SAT(16'd5)) dut (
      .inp_clk              (clk),
      .inp_rst              (rst),
      .inp_fetchReq         (fetch_req),
      .inp_address          (address),
      .inp_cacheHit         (cache_hit),
      .inp_cacheInstruction (cache_instr),
      .out_cacheAddress     (cache_addr),
      .out_cacheWrite       (cache_write),
      .out_cacheLine        (cache_line),
      .out_memReq           (mem_req),
      .out_memAddress       (mem_addr),
      .inp_memAck           (mem_ack),
      .inp_memData          (mem_data),
      .out_instruction      (instr),
      .out_valid            (valid),
      .out_stall            (stall),
      .out_error            (error),
      .out_missCount        (miss_cnt)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input logic [15:0] d, input int idle);
      repeat (idle) begin
         step;
         mem_ack = 0;
      end
      step;
      mem_ack  = 1;
      mem_data = d;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      #3;
      chk("rst_memreq", mem_req, 0);
      chk("rst_valid", valid, 0);
      chk("rst_stall", stall, 0);
      chk("rst_error", error, 0);
      chk("rst_miss", miss_cnt, 0);
      chk("rst_memaddr", mem_addr, 0);
      chk("rst_line", cache_line, 0);
      chk("rst_instr", instr, 0);
      chk("rst_write", cache_write, 0);
      step;
      rst = 0;
      // hit served combinationally
      step;
      fetch_req = 1; address = 16'h0002; cache_hit = 1; cache_instr = 16'h1234;
      #2;
      chk("hit_valid", valid, 1);
      chk("hit_instr", instr, 16'h1234);
      chk("hit_stall", stall, 0);
      chk("hit_memreq", mem_req, 0);
      chk("hit_caddr", cache_addr, 16'h0002);
      step;
      fetch_req = 0;
      #2;
      chk("hit_miss", miss_cnt, 0);
      // miss at 0x000A with two idle cycles between beats
      step;
      fetch_req = 1; address = 16'h000A; cache_hit = 0;
      #2;
      chk("miss_stall", stall, 1);
      chk("miss_valid", valid, 0);
      step;
      address = 16'h0100;
      #2;
      chk("req_memreq", mem_req, 1);
      chk("req_memaddr", mem_addr, 16'h0008);
      chk("req_caddr", cache_addr, 16'h000A);
      chk("req_miss", miss_cnt, 1);
      beat(16'h1000, 2);
      beat(16'h1100, 2);
      beat(16'h1110, 2);
      beat(16'h1111, 2);
      step;
      mem_ack = 0;
      #2;
      chk("fill_write", cache_write, 1);
      chk("fill_line", cache_line, 64'h1111_1110_1100_1000);
      chk("fill_valid", valid, 1);
      chk("fill_instr", instr, 16'h1100);
      chk("fill_memreq", mem_req, 0);
      chk("fill_stall", stall, 0);
      step;
      fetch_req = 0;
      #2;
      chk("post_write", cache_write, 0);
      chk("post_stall", stall, 0);
      // timeout: 64 ack-less REQ cycles
      step;
      fetch_req = 1; address = 16'h0020;
      step;
      repeat (63) step;
      #1;
      chk("tmo_early_err", error, 0);
      chk("tmo_early_req", mem_req, 1);
      step;
      #1;
      chk("tmo_err", error, 1);
      chk("tmo_memreq", mem_req, 0);
      chk("tmo_stall", stall, 1);
      chk("tmo_valid", valid, 0);
      chk("tmo_miss", miss_cnt, 2);
      mem_ack = 1; mem_data = 16'hDEAD;
      step;
      mem_ack = 0;
      step;
      #1;
      chk("tmo_ack_line", cache_line, 64'h1111_1110_1100_1000);
      chk("tmo_ack_err", error, 1);
      chk("tmo_ack_write", cache_write, 0);
      // reset in the middle of a refill
      rst = 1;
      step;
      rst = 0;
      step;
      fetch_req = 1; address = 16'h0010; cache_hit = 0;
      step;
      beat(16'hAAAA, 0);
      beat(16'hBBBB, 0);
      step;
      mem_ack = 0;
      #1;
      chk("rr_memreq_before", mem_req, 1);
      rst = 1; fetch_req = 0;
      #1;
      chk("rr_memreq", mem_req, 0);
      chk("rr_write", cache_write, 0);
      chk("rr_miss", miss_cnt, 0);
      chk("rr_line", cache_line, 0);
      step;
      rst = 0; fetch_req = 1; address = 16'h0004; cache_hit = 1; cache_instr = 16'h5678;
      #2;
      chk("rr_hit_valid", valid, 1);
      chk("rr_hit_instr", instr, 16'h5678);
      chk("rr_hit_write", cache_write, 0);
      // fetchReq dropped after the first beat
      step;
      address = 16'h0016; cache_hit = 0;
      step;
      beat(16'h2000, 0);
      fetch_req = 0;
      beat(16'h2001, 1);
      #1;
      chk("drop_req_valid", valid, 0);
      beat(16'h2002, 0);
      beat(16'h2003, 0);
      step;
      mem_ack = 0;
      #2;
      chk("drop_write", cache_write, 1);
      chk("drop_line", cache_line, 64'h2003_2002_2001_2000);
      chk("drop_valid", valid, 0);
      chk("drop_miss", miss_cnt, 1);
      // saturation of the miss counter at its limit
      for (int i = 0; i < 6; i++) begin
         step;
         fetch_req = 1; address = 16'(i * 8); cache_hit = 0;
         step;
         repeat (4) beat(16'(i), 0);
         step;
         mem_ack = 0; fetch_req = 0;
         #2;
         chk($sformatf("sat_%0d", i), miss_cnt, (i + 2 > 5) ? 64'd5 : 64'(i + 2));
      end
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
